// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Brief  : Shared state encodings, mode constants and requester count.
// Rev    : 1.0
// ============================================================================
package arb_pkg;

  localparam int   NUM_REQ    = 4;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rot_pri_enc_4to2.sv
`default_nettype none
// ============================================================================
// Module : rot_pri_enc_4to2
// Brief  : Rotating priority encoder; search order ptr, ptr-1, ptr-2, ptr-3.
// Rev    : 1.0
// ============================================================================
module rot_pri_enc_4to2
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         idx,
  output logic               valid
);

  // Lowest priority visited first so the ptr position overrides last.
  always_comb begin
    idx = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr - 2'(k)]) begin
        idx = ptr - 2'(k);
      end
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/pri_arb_4ch.sv
`default_nettype none
// ============================================================================
// Module : pri_arb_4ch
// Brief  : 4-channel arbiter, fixed or round-robin, with hold timeout.
// Rev    : 1.0
// ============================================================================
module pri_arb_4ch
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  input  logic       mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state,   w_state_nxt;
  logic [3:0]       r_gnt,     w_gnt_nxt;
  logic [1:0]       r_gnt_id,  w_gnt_id_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [1:0]       r_ptr,     w_ptr_nxt;

  logic [1:0] w_enc_ptr;
  logic [1:0] w_enc_idx;
  logic       w_enc_valid;
  logic       w_owner_req;

  // Fixed mode is the rotating search anchored at the top requester.
  assign w_enc_ptr   = (mode == MODE_RR) ? r_ptr : 2'd3;
  assign w_owner_req = req[r_gnt_id];

  rot_pri_enc_4to2 u_enc (
    .req   (req),
    .ptr   (w_enc_ptr),
    .idx   (w_enc_idx),
    .valid (w_enc_valid)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;

    case (r_state)
      IDLE: begin
        if (w_enc_valid) begin
          w_state_nxt  = GRANT;
          w_gnt_nxt    = 4'b0001 << w_enc_idx;
          w_gnt_id_nxt = w_enc_idx;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = '0;
        end
      end

      GRANT: begin
        if (done || !w_owner_req || (r_cnt == CNT_LAST)) begin
          w_state_nxt   = RELEASE;
          w_gnt_nxt     = 4'b0000;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = r_gnt_id - 2'd1;
          // A voluntary release (done or dropped request) is never a timeout.
          w_timeout_nxt = !done && w_owner_req;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= 4'b0000;
      r_gnt_id  <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= 2'd3;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pri_arb_4ch.sv
`default_nettype none
// Bench for pri_arb_4ch: directed scenarios plus random traffic, all checked
// every cycle against a behavioural owner/hold-time model.
module tb_pri_arb_4ch;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pri_arb_4ch #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .mode    (mode),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Model: owner = -1 when nothing granted; hold = cycles held so far;
  // cool = cycles still to wait before a new arbitration may happen.
  int m_owner = -1;
  int m_hold  = 0;
  int m_cool  = 0;
  int m_ptr   = 3;
  int m_last  = 0;
  bit m_pulse = 1'b0;

  function automatic int pick(logic [3:0] r, logic m, int p);
    if (m == 1'b0) begin
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < 4; k++) if (r[(p - k + 4) % 4]) return (p - k + 4) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_hold = 0; m_cool = 0; m_ptr = 3; m_last = 0; m_pulse = 1'b0;
    end else if (m_owner >= 0) begin
      m_hold = m_hold + 1;
      if (done || !req[m_owner] || m_hold >= TO) begin
        m_pulse = !done && req[m_owner];
        m_ptr   = (m_owner + 3) % 4;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool  = m_cool - 1;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (req != 4'b0000) begin
        m_owner = pick(req, mode, m_ptr);
        m_last  = m_owner;
        m_hold  = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic [1:0] e_id;
    logic       e_busy;
    if (chk_en) begin
      e_gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      e_id   = 2'(m_last);
      e_busy = (m_owner >= 0);
      total++;
      if (gnt !== e_gnt || gnt_id !== e_id || busy !== e_busy || timeout !== m_pulse) begin
        bad++;
        $display("FAIL model_cmp t=%0t gnt=%b want=%b id=%0d want=%0d busy=%b want=%b to=%b want=%b",
                 $time, gnt, e_gnt, gnt_id, e_id, busy, e_busy, timeout, m_pulse);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_ids[4] = '{2, 1, 0, 3};

    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_id", {2'b00, gnt_id}, 4'd0);
    check("rst_busy", {3'b000, busy}, 4'd0);
    check("rst_to", {3'b000, timeout}, 4'd0);

    // Fixed priority
    mode = 1'b0; req = 4'b0110;
    tick();
    check("fix_gnt", gnt, 4'b0100);
    check("fix_id", {2'b00, gnt_id}, 4'd2);
    check("fix_busy", {3'b000, busy}, 4'd1);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    check("fix_rel_gnt", gnt, 4'b0000);
    check("fix_rel_busy", {3'b000, busy}, 4'd0);
    tick();

    // Round-robin rotation 3,2,1,0,3
    do_reset();
    mode = 1'b1; req = 4'b1111;
    tick();
    check("rr_id0", {2'b00, gnt_id}, 4'd3);
    for (int n = 0; n < 4; n++) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rr_gap1", gnt, 4'b0000);
      tick();
      check("rr_gap2", gnt, 4'b0000);
      tick();
      check("rr_id", {2'b00, gnt_id}, 4'(exp_ids[n]));
      check("rr_gnt", gnt, 4'(1 << exp_ids[n]));
    end
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;

    // Timeout with TIMEOUT=4
    do_reset();
    mode = 1'b0; req = 4'b0001;
    tick();
    check("to_h1", gnt, 4'b0001);
    for (int n = 2; n <= 4; n++) begin
      tick();
      check("to_hold", gnt, 4'b0001);
      check("to_nopulse", {3'b000, timeout}, 4'd0);
    end
    tick();
    check("to_pulse", {3'b000, timeout}, 4'd1);
    check("to_gnt0", gnt, 4'b0000);
    tick();
    check("to_pulse_end", {3'b000, timeout}, 4'd0);
    check("to_idle", gnt, 4'b0000);
    tick();
    check("to_regrant", gnt, 4'b0001);

    // Done/timeout collision in the 4th hold cycle
    do_reset();
    req = 4'b0001;
    tick();
    tick(); tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("col_gnt", gnt, 4'b0000);
    check("col_to", {3'b000, timeout}, 4'd0);

    // Request drop, then round-robin resumes from (id-1) mod 4
    do_reset();
    mode = 1'b0; req = 4'b1000;
    tick();
    check("drop_id", {2'b00, gnt_id}, 4'd3);
    tick();
    req = 4'b0000;
    tick();
    check("drop_rel", gnt, 4'b0000);
    check("drop_to", {3'b000, timeout}, 4'd0);
    req = 4'b1001; mode = 1'b1;
    tick();
    tick();
    check("drop_ptr_id", {2'b00, gnt_id}, 4'd0);
    req = 4'b0000;
    tick(); tick(); tick();

    // Mid-grant reset restores ptr=3
    do_reset();
    mode = 1'b1; req = 4'b0010;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    check("mr_id_pre", {2'b00, gnt_id}, 4'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_gnt", gnt, 4'b0000);
    check("mr_busy", {3'b000, busy}, 4'd0);
    check("mr_id", {2'b00, gnt_id}, 4'd0);
    req = 4'b1111;
    tick();
    check("mr_to", {3'b000, timeout}, 4'd0);
    check("mr_first", {2'b00, gnt_id}, 4'd3);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) mode = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req = 4'b0000; done = 1'b0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pri_arb_4ch.md
PRI_ARB_4CH -- requirements
Module: pri_arb_4ch

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of consecutive cycles a grant may be held.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port req, input, 4: request lines; req[3] has the highest fixed priority.
REQ-005 Port done, input, 1: the current owner releases the grant.
REQ-006 Port mode, input, 1: arbitration mode; 0 = fixed priority, 1 = round-robin.
REQ-007 Port gnt, output, 4: registered grant; one-hot or all zero.
REQ-008 Port gnt_id, output, 2: registered index of the current owner.
REQ-009 Port busy, output, 1: registered; high while any grant is held.
REQ-010 Port timeout, output, 1: registered one-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-012 In IDLE, if any req bit is high at edge N, the FSM SHALL enter GRANT, and gnt, gnt_id and busy SHALL be valid after edge N (latency 1).
REQ-013 In fixed mode, the winner SHALL be the highest set index of req.
REQ-014 In round-robin mode, the winner SHALL be the first set bit in search order ptr, ptr-1, ptr-2, ptr-3 (mod 4).
REQ-015 mode SHALL be sampled only in IDLE; a change during GRANT or RELEASE SHALL take effect at the next arbitration.
REQ-016 In GRANT, the grant SHALL be held while req[gnt_id] stays high and done is low; other requests SHALL be ignored (no preemption).
REQ-017 GRANT SHALL go to RELEASE when done=1, or req[gnt_id]=0, or the hold counter reaches TIMEOUT-1.
REQ-018 If done and the timeout occur in the same cycle, done SHALL take precedence and timeout SHALL not pulse.
REQ-019 The hold counter SHALL clear on entry to GRANT, increment each GRANT cycle, and be at least $clog2(TIMEOUT) bits wide with no wrap before TIMEOUT-1.
REQ-020 On a timeout release, the timeout output SHALL pulse high for exactly the first RELEASE cycle.
REQ-021 In RELEASE, gnt SHALL be 0 and busy SHALL be 0 for exactly one cycle.
REQ-022 In RELEASE, ptr SHALL be set to (gnt_id-1) mod 4 in both modes.
REQ-023 RELEASE SHALL always return to IDLE, giving a minimum of 2 idle cycles between consecutive grants.
REQ-024 If req=0 in IDLE, outputs SHALL remain 0 and the state SHALL remain IDLE.
REQ-025 gnt_id SHALL hold its last value when gnt=0; it is meaningful only when busy=1.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, counter=0, ptr=3.
REQ-027 Reset asserted during GRANT SHALL drop gnt after that same edge, with no RELEASE cycle and no timeout pulse.
REQ-028 Reset SHALL override every other input.

Structure
REQ-029 Shared package arb_pkg SHALL hold the state encodings (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2), the MODE_FIXED and MODE_RR constants, and the requester count 4.
REQ-030 The winner search SHALL be a combinational sub-module rot_pri_enc_4to2 (inputs req and ptr; outputs idx and valid); fixed mode SHALL use it with ptr=3.
REQ-031 All outputs SHALL be driven directly from registers.

Verification
REQ-032 Fixed priority: mode=0, req=4'b0110 -> gnt=4'b0100, gnt_id=2 one cycle later.
REQ-033 Round-robin rotation: mode=1, req held at 4'b1111 and done pulsed each grant -> gnt_id sequence 3,2,1,0,3.
REQ-034 Timeout: TIMEOUT=4, req=4'b0001 held, done=0 -> gnt high for 4 cycles, then timeout=1 and gnt=0 for 1 cycle, then re-grant after IDLE.
REQ-035 Done/timeout collision: done=1 in the 4th hold cycle with TIMEOUT=4 -> RELEASE entered with timeout=0.
REQ-036 Request drop: owner drops req mid-grant -> RELEASE next cycle, ptr=(id-1) mod 4.
REQ-037 Mid-grant reset: rst=1 during GRANT -> all outputs 0 after that edge, ptr=3, and the next arbitration picks req[3] first.
